// File: rtl/div_issue_ctrl_pkg.sv
// Shared op codes, divider handshake constants and issue FSM states.
// Imported by the divide issue controller and its bench.
package div_issue_ctrl_pkg;

  localparam logic [4:0]  ALU_NOP        = 5'b00000;
  localparam logic [4:0]  DIV_CONTROL    = 5'b01010;
  localparam logic [4:0]  DIVU_CONTROL   = 5'b01011;

  localparam logic        DivStart       = 1'b1;
  localparam logic        DivStop        = 1'b0;
  localparam logic        DivResultReady = 1'b1;
  localparam logic [31:0] ZeroWord       = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } div_state_e;

  function automatic logic is_div(input logic [4:0] op);
    return (op == DIV_CONTROL) || (op == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/div_issue_ctrl.sv
// Divide issue/hold/drain controller between EX and the multi-cycle divider.
// Optional DIV_ZERO_TRAP_EN traps zero divisors instead of issuing them.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [4:0]  div_op_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        stallreq_o,
  output logic        whilo_o,
`ifdef DIV_ZERO_TRAP_EN
  output logic        div_zero_exc_o,
`endif
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  div_state_e  r_state;
  logic [4:0]  r_op;
  logic [31:0] r_opd1;
  logic [31:0] r_opd2;

  logic w_div;
  logic w_zero;
  logic w_issue;
  logic w_done;

  assign w_div = is_div(op_i);
`ifdef DIV_ZERO_TRAP_EN
  assign w_zero = (reg2_i == ZeroWord);
`else
  assign w_zero = 1'b0;
`endif
  assign w_issue = (r_state == S_IDLE) & w_div & ~flush_i & ~w_zero;
  assign w_done  = flush_i | (div_ready_i == DivResultReady);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op    <= ALU_NOP;
      r_opd1  <= ZeroWord;
      r_opd2  <= ZeroWord;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_BUSY;
            r_op    <= op_i;
            r_opd1  <= reg1_i;
            r_opd2  <= reg2_i;
          end
        end
        S_BUSY: begin
          if (w_done) r_state <= S_DRAIN;
        end
        S_DRAIN: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset gates every output so nothing leaks from live EX inputs.
  always_comb begin
    div_op_o      = ALU_NOP;
    div_opdata1_o = ZeroWord;
    div_opdata2_o = ZeroWord;
    div_start_o   = DivStop;
    div_annul_o   = flush_i & rst;
    stallreq_o    = 1'b0;
    whilo_o       = 1'b0;
    hi_o          = ZeroWord;
    lo_o          = ZeroWord;
`ifdef DIV_ZERO_TRAP_EN
    div_zero_exc_o = rst & (r_state == S_IDLE) & w_div & ~flush_i & w_zero;
`endif
    if (rst) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            div_op_o      = op_i;
            div_opdata1_o = reg1_i;
            div_opdata2_o = reg2_i;
            div_start_o   = DivStart;
            stallreq_o    = 1'b1;
          end
        end
        S_BUSY: begin
          div_op_o      = r_op;
          div_opdata1_o = r_opd1;
          div_opdata2_o = r_opd2;
          if (flush_i) begin
            div_start_o = DivStop;
          end else if (div_ready_i == DivResultReady) begin
            whilo_o = 1'b1;
            hi_o    = div_result_i[63:32];
            lo_o    = div_result_i[31:0];
          end else begin
            div_start_o = DivStart;
            stallreq_o  = 1'b1;
          end
        end
        S_DRAIN: begin
          div_op_o      = r_op;
          div_opdata1_o = r_opd1;
          div_opdata2_o = r_opd2;
          stallreq_o    = w_div;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed and randomized bench for div_issue_ctrl; the bench plays the divider.
// Build with DIV_ZERO_TRAP_EN defined to exercise the zero-divisor trap.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  op_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic [4:0]  div_op_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_start_o;
  logic        div_annul_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_exc_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  div_issue_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .op_i          (op_i),
    .reg1_i        (reg1_i),
    .reg2_i        (reg2_i),
    .flush_i       (flush_i),
    .div_result_i  (div_result_i),
    .div_ready_i   (div_ready_i),
    .div_op_o      (div_op_o),
    .div_opdata1_o (div_opdata1_o),
    .div_opdata2_o (div_opdata2_o),
    .div_start_o   (div_start_o),
    .div_annul_o   (div_annul_o),
    .stallreq_o    (stallreq_o),
    .whilo_o       (whilo_o),
`ifdef DIV_ZERO_TRAP_EN
    .div_zero_exc_o(div_zero_exc_o),
`endif
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural divide: truncating quotient, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (op == DIV_CONTROL) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic idle_quiet(input string tag);
    chk({tag, "_start"}, div_start_o, 1'b0);
    chk({tag, "_stall"}, stallreq_o, 1'b0);
    chk({tag, "_whilo"}, whilo_o, 1'b0);
    chk({tag, "_hi"}, hi_o, 32'h0);
    chk({tag, "_lo"}, lo_o, 32'h0);
  endtask

  // Starts at a negedge in IDLE and returns at the negedge of the next IDLE.
  task automatic do_div(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input bit b2b,
                        output logic [31:0] ohi, output logic [31:0] olo);
    logic [63:0] exp;
    exp = ref_div(op, a, b);
    op_i = op; reg1_i = a; reg2_i = b;
    flush_i = 1'b0; div_ready_i = 1'b0;
    #1;
    chk("issue_start", div_start_o, 1'b1);
    chk("issue_stall", stallreq_o, 1'b1);
    chk("issue_op", div_op_o, op);
    chk("issue_a", div_opdata1_o, a);
    chk("issue_b", div_opdata2_o, b);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      reg1_i = $urandom; reg2_i = $urandom;
      div_result_i = {$urandom, $urandom};
      #1;
      chk("busy_start", div_start_o, 1'b1);
      chk("busy_stall", stallreq_o, 1'b1);
      chk("busy_whilo", whilo_o, 1'b0);
      chk("busy_held_a", div_opdata1_o, a);
      chk("busy_held_b", div_opdata2_o, b);
    end
    @(negedge clk);
    reg1_i = a; reg2_i = b;
    div_ready_i = 1'b1; div_result_i = exp;
    #1;
    chk("done_whilo", whilo_o, 1'b1);
    chk("done_start", div_start_o, 1'b0);
    chk("done_stall", stallreq_o, 1'b0);
    chk("done_hi", hi_o, exp[63:32]);
    chk("done_lo", lo_o, exp[31:0]);
    ohi = hi_o; olo = lo_o;
    @(negedge clk);
    div_ready_i = 1'b0;
    op_i = b2b ? op : ALU_NOP;
    #1;
    chk("drain_start", div_start_o, 1'b0);
    chk("drain_whilo", whilo_o, 1'b0);
    chk("drain_stall", stallreq_o, b2b);
    chk("drain_held_a", div_opdata1_o, a);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] h, l;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b0; op_i = DIV_CONTROL; reg1_i = 32'd55; reg2_i = 32'd5;
    flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 64'h1234_5678_9abc_def0;
    #2;
    idle_quiet("rst");
    chk("rst_annul", div_annul_o, 1'b0);
    chk("rst_op", div_op_o, 5'h0);
    chk("rst_a", div_opdata1_o, 32'h0);

    @(negedge clk);
    rst = 1'b1; op_i = ALU_NOP; flush_i = 1'b0;
    #1;
    idle_quiet("post_rst_stale");

    @(negedge clk);
    div_ready_i = 1'b0;
    do_div(DIV_CONTROL, 32'd100, 32'd7, 6, 1'b0, h, l);
    chk("d100_7_hi", h, 32'd2);
    chk("d100_7_lo", l, 32'd14);

    do_div(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 3, 1'b0, h, l);
    chk("dm7_2_hi", h, 32'hFFFF_FFFF);
    chk("dm7_2_lo", l, 32'hFFFF_FFFD);

    do_div(DIVU_CONTROL, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, h, l);
    chk("du_hi", h, 32'd1);
    chk("du_lo", l, 32'h7FFF_FFFF);

    op_i = DIV_CONTROL; reg1_i = 32'd40; reg2_i = 32'd3;
    #1;
    chk("flush_issue", div_start_o, 1'b1);
    for (int i = 0; i < 9; i++) @(negedge clk);
    flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 64'h1_0000_000D;
    #1;
    chk("flush_annul", div_annul_o, 1'b1);
    chk("flush_start", div_start_o, 1'b0);
    chk("flush_whilo", whilo_o, 1'b0);
    chk("flush_lo", lo_o, 32'h0);
    @(negedge clk);
    flush_i = 1'b0; div_ready_i = 1'b0; op_i = ALU_NOP;
    #1;
    chk("flush_drain_annul", div_annul_o, 1'b0);
    chk("flush_drain_start", div_start_o, 1'b0);
    @(negedge clk);
    do_div(DIV_CONTROL, 32'd40, 32'd3, 2, 1'b0, h, l);

    do_div(DIV_CONTROL, 32'd50, 32'd6, 2, 1'b1, h, l);
    chk("b2b1_lo", l, 32'd8);
    do_div(DIV_CONTROL, 32'd50, 32'd6, 4, 1'b0, h, l);
    chk("b2b2_lo", l, 32'd8);
    chk("b2b2_hi", h, 32'd2);

    op_i = DIVU_CONTROL; reg1_i = 32'd10; reg2_i = 32'd2; flush_i = 1'b1;
    #1;
    chk("idle_flush_annul", div_annul_o, 1'b1);
    idle_quiet("idle_flush");
    @(negedge clk);
    do_div(DIVU_CONTROL, 32'd10, 32'd2, 1, 1'b0, h, l);

    for (int i = 0; i < 4; i++) begin
      op_i = 5'(i + 1); reg1_i = $urandom; reg2_i = $urandom;
      div_ready_i = 1'b1; div_result_i = {$urandom, $urandom};
      #1;
      idle_quiet("nondiv");
      chk("nondiv_annul", div_annul_o, 1'b0);
      @(negedge clk);
    end
    div_ready_i = 1'b0;

`ifdef DIV_ZERO_TRAP_EN
    op_i = DIV_CONTROL; reg1_i = 32'd9; reg2_i = 32'h0;
    #1;
    chk("dz_exc", div_zero_exc_o, 1'b1);
    idle_quiet("dz");
    @(negedge clk);
    op_i = ALU_NOP;
    #1;
    chk("dz_exc_clear", div_zero_exc_o, 1'b0);
    @(negedge clk);
    do_div(DIV_CONTROL, 32'd9, 32'd4, 1, 1'b0, h, l);
    chk("dz_after_lo", l, 32'd2);
`else
    do_div(DIV_CONTROL, 32'd9, 32'h0, 3, 1'b0, h, l);
    chk("dz_hi", h, 32'h0);
    chk("dz_lo", l, 32'h0);
`endif

    op_i = DIV_CONTROL; reg1_i = 32'd77; reg2_i = 32'd5;
    #1;
    chk("mid_issue", div_start_o, 1'b1);
    for (int i = 0; i < 3; i++) @(negedge clk);
    flush_i = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    idle_quiet("mid_rst");
    chk("mid_rst_annul", div_annul_o, 1'b0);
    chk("mid_rst_a", div_opdata1_o, 32'h0);
    @(negedge clk);
    rst = 1'b1; flush_i = 1'b0; op_i = ALU_NOP;
    div_ready_i = 1'b1; div_result_i = 64'hDEAD_0000_BEEF;
    #1;
    idle_quiet("post_mid_rst");
    @(negedge clk);
    div_ready_i = 1'b0;
    do_div(DIV_CONTROL, 32'd9, 32'd3, 2, 1'b0, h, l);
    chk("r9_3_lo", l, 32'd3);
    chk("r9_3_hi", h, 32'd0);

    for (int i = 0; i < 25; i++) begin
      rop = ($urandom_range(0, 1) == 0) ? DIV_CONTROL : DIVU_CONTROL;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (rb == 32'h0) rb = 32'd1;
      do_div(rop, ra, rb, $urandom_range(0, 8), 1'($urandom_range(0, 1)), h, l);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 op_i  input  5  EX-stage ALU control; DIV_CONTROL/DIVU_CONTROL request a divide.
REQ-005 reg1_i, reg2_i  input  32 each  dividend and divisor from EX.
REQ-006 flush_i  input  1  pipeline flush; kills any in-flight divide.
REQ-007 div_result_i  input  64  divider result {remainder, quotient}.
REQ-008 div_ready_i  input  1  divider result valid.
REQ-009 div_op_o  output  5  op forwarded to divider.
REQ-010 div_opdata1_o, div_opdata2_o  output  32 each  operands to divider.
REQ-011 div_start_o  output  1  divider start/hold.
REQ-012 div_annul_o  output  1  divider cancel.
REQ-013 stallreq_o  output  1  stall request to pipeline control.
REQ-014 whilo_o  output  1  HI/LO write strobe.
REQ-015 hi_o, lo_o  output  32 each  remainder and quotient for HI/LO.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and DRAIN.
REQ-017 In IDLE, with a divide op_i and flush_i low, the block SHALL assert div_start_o and stallreq_o combinationally and drive div_op_o/opdata from op_i/reg1_i/reg2_i; next state BUSY.
REQ-018 Operands and op SHALL be registered on entry to BUSY and held stable until DRAIN.
REQ-019 In BUSY, div_start_o and stallreq_o SHALL stay high until div_ready_i is seen.
REQ-020 In BUSY with div_ready_i high and flush_i low, the block SHALL drive div_start_o low, stallreq_o low, whilo_o high for exactly that cycle, hi_o=div_result_i[63:32], lo_o=div_result_i[31:0]; next state DRAIN.
REQ-021 DRAIN SHALL last exactly one cycle with div_start_o low, so the divider returns to free; next state IDLE.
REQ-022 A divide presented during DRAIN SHALL see stallreq_o high and be issued from IDLE next cycle; back-to-back divides therefore cost one extra cycle.
REQ-023 flush_i high in BUSY SHALL drive div_annul_o high and div_start_o low that cycle, suppress whilo_o even if div_ready_i is high, and go to DRAIN.
REQ-024 flush_i high in IDLE SHALL block issue; div_annul_o SHALL equal flush_i in all states.
REQ-025 With non-divide op_i, all strobes SHALL be low and hi_o/lo_o SHALL be 0.
REQ-026 End-to-end latency from issue to whilo_o SHALL be set only by div_ready_i; the block adds no cycle on the result path.

Reset
REQ-027 Asserting rst SHALL force IDLE and clear all outputs and held operands to 0, including mid-divide.
REQ-028 After reset release, the first divide SHALL issue normally with no stale write.

Configuration
REQ-029 Macro DIV_ZERO_TRAP_EN SHALL, when defined, add output div_zero_exc_o (1 bit). A divide with reg2_i==0 in IDLE then pulses that output for one cycle, does not start the divider, does not stall and does not write HI/LO.
REQ-030 Without DIV_ZERO_TRAP_EN, a zero divisor SHALL be issued normally and its result (0,0) written.

Structure
REQ-031 Op codes (DIV_CONTROL, DIVU_CONTROL), DivStart/DivStop, DivResultReady and ZeroWord SHALL come from the shared defines.h/alu_defines.vh.
REQ-032 The new state encodings SHALL be added to defines.h.
REQ-033 The block SHALL be a single module with no sub-module; the divider is instantiated by the parent.

Verification
REQ-034 DIV 100/7 -> one whilo_o pulse, hi_o=2, lo_o=14; stallreq_o high from issue until that cycle.
REQ-035 DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> lo_o=0x7FFFFFFF, hi_o=1.
REQ-036 flush_i pulsed 10 cycles after issue -> div_annul_o high that cycle, no whilo_o, IDLE two cycles later.
REQ-037 Two back-to-back DIVs -> second issues exactly two cycles after first whilo_o; both results are correct.
REQ-038 Zero divisor: with DIV_ZERO_TRAP_EN -> div_zero_exc_o single pulse, no start, no stall; without -> whilo_o with hi_o=lo_o=0.
REQ-039 rst asserted mid-BUSY -> all outputs 0 immediately; a subsequent 9/3 -> lo_o=3, hi_o=0.
